// File: rtl/pwm_duty_decoder_pkg.sv
// Shared constants for the PWM duty decoder: duty width, window length, synchroniser depth.
package pwm_duty_decoder_pkg;
  localparam int PWM_W       = 8;
  localparam int PWM_PERIOD  = 2**PWM_W;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/pwm_duty_channel.sv
// One decoded PWM line: synchroniser, high-time counter, saturating capture and change flag.
module pwm_duty_channel
  import pwm_duty_decoder_pkg::*;
#(
  parameter int W = PWM_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  input  logic         cap,
  input  logic         warm,
  output logic [W-1:0] duty,
  output logic         changed
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [W:0]             high_q, high_d, cap_val;
  logic [W-1:0]           duty_q, duty_d, cap_sat;
  logic                   changed_q, changed_d;
  logic                   s;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s         = sync_q[SYNC_STAGES-1];
    // The capture-cycle sample is folded in so the window is exactly 2^W samples.
    cap_val   = high_q + {{W{1'b0}}, s};
    cap_sat   = cap_val[W] ? {W{1'b1}} : cap_val[W-1:0];
    high_d    = cap ? '0 : cap_val;
    duty_d    = duty_q;
    changed_d = changed_q;
    if (cap && !warm) begin
      duty_d    = cap_sat;
      changed_d = (cap_sat != duty_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      changed_q <= changed_d;
    end
  end

  assign duty    = duty_q;
  assign changed = changed_q;
endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers per-channel PWM duty over a free-running 2^W-clock window and hands it
// out through a valid/ready handshake with overrun and change reporting.
module pwm_duty_decoder
  import pwm_duty_decoder_pkg::*;
#(
  parameter int W        = PWM_W,
  parameter int CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   pwm_in,
  output logic [CHANNELS*W-1:0] duty,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun,
  output logic [CHANNELS-1:0]   changed
);
  logic [W-1:0] win_q, win_d;
  logic         warm_q, warm_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic         cap;

  always_comb begin
    cap       = &win_q;
    win_d     = win_q + 1'b1;
    warm_d    = warm_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (cap) begin
      // First window after reset holds synchroniser fill and is discarded.
      warm_d = 1'b0;
      if (!warm_q) begin
        valid_d   = 1'b1;
        overrun_d = valid_q & ~ready;
      end
    end else if (valid_q && ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q     <= '0;
      warm_q    <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      warm_q    <= warm_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_duty_channel #(.W(W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pwm_in  (pwm_in[g]),
      .cap     (cap),
      .warm    (warm_q),
      .duty    (duty[g*W +: W]),
      .changed (changed[g])
    );
  end

  assign valid   = valid_q;
  assign overrun = overrun_q;
endmodule
